// File: rtl/cache_arbiter.sv
// cache_arbiter: fair arbiter sharing one cacheline adaptor between I-cache and D-cache
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t state, state_n;
    logic   last_grant, last_grant_n;
    logic   d_pend;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
        end
    end
    assign d_pend = d_read | d_write;
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        if (state == IDLE)
            state_n = (i_read && (!d_pend || last_grant)) ? SERVE_I : d_pend ? SERVE_D : IDLE;
        else if (mem_resp) begin
            state_n      = IDLE;
            last_grant_n = state == SERVE_D;
        end
    end
    assign mem_read    = state == SERVE_I || (state == SERVE_D && d_read && !d_write);
    assign mem_write   = state == SERVE_D && d_write;
    assign mem_address = state == SERVE_I ? i_address : state == SERVE_D ? d_address : '0;
    assign mem_wdata   = state == SERVE_D ? d_wdata : '0;
    assign i_resp      = state == SERVE_I && mem_resp;
    assign d_resp      = state == SERVE_D && mem_resp;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;
endmodule
